// File: rtl/pwm_breathe_mc_if.sv
// Configuration and output bundle for pwm_breathe_mc: run control, per-channel
// mode/duty strobes in, PWM lines, applied duty and period pulse out.
interface pwm_breathe_mc_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
);
    logic                      enable;
    logic [2*CHANNELS-1:0]     mode;
    logic [CNT_W*CHANNELS-1:0] duty_in;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS-1:0]       dout;
    logic [CNT_W*CHANNELS-1:0] duty_out;
    logic                      cycle_end;

    modport master (
        output enable, mode, duty_in, load,
        input  dout, duty_out, cycle_end
    );

    modport slave (
        input  enable, mode, duty_in, load,
        output dout, duty_out, cycle_end
    );
endinterface

// File: rtl/pwm_breathe_mc.sv
// Multi-channel PWM with a shared period counter; each channel is off, fixed,
// triangle-breathing or ramp-and-hold, with duty changes applied only at period ends.
module pwm_breathe_mc #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STEP         = 5,
    parameter int unsigned CYC_PER_STEP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pwm_breathe_mc_if.slave         pwm_if
);

    localparam int unsigned SC_W = (CYC_PER_STEP > 1) ? $clog2(CYC_PER_STEP) : 1;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
    localparam logic [CNT_W:0]   PERIOD_X = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W + 1)'(STEP);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(CYC_PER_STEP - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_FIXED   = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_RAMP    = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [SC_W-1:0]                 step_q, step_d;
    logic                            cyc_end_q, cyc_end_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0][CNT_W-1:0]  shadow_q, shadow_d;
    logic [CHANNELS-1:0]             pend_q, pend_d;
    logic [CHANNELS-1:0]             dout_q, dout_d;
    dir_e                            dir_q [CHANNELS];
    dir_e                            dir_d [CHANNELS];

    logic [CHANNELS-1:0][1:0]        mode_v;
    logic [CHANNELS-1:0][CNT_W-1:0]  duty_in_v;
    logic                            wrap_c;

    assign mode_v    = pwm_if.mode;
    assign duty_in_v = pwm_if.duty_in;
    assign wrap_c    = pwm_if.enable && (cnt_q == LAST_C);

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] v);
        return (v > PERIOD_C) ? PERIOD_C : v;
    endfunction

    // Next-state: counter, step divider, shadow capture and boundary duty update.
    always_comb begin
        cnt_d     = cnt_q;
        step_d    = step_q;
        cyc_end_d = 1'b0;
        duty_d    = duty_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        dout_d    = '0;
        dir_d     = dir_q;

        if (pwm_if.enable) begin
            cnt_d     = wrap_c ? '0 : cnt_q + CNT_W'(1);
            cyc_end_d = (cnt_d == LAST_C);
        end

        if (wrap_c) begin
            step_d = (step_q == SC_LAST) ? '0 : step_q + SC_W'(1);
        end

        for (int i = 0; i < CHANNELS; i++) begin
            dout_d[i] = pwm_if.enable && (mode_v[i] != MODE_OFF) && (cnt_q < duty_q[i]);

            if (pwm_if.load[i]) begin
                shadow_d[i] = duty_in_v[i];
            end
            // A load in breathe/ramp re-seeds the duty at the next boundary instead of stepping.
            pend_d[i] = (pend_q[i] && !wrap_c) || (pwm_if.load[i] && mode_v[i][1]);

            if (wrap_c) begin
                case (mode_v[i])
                    MODE_OFF: begin
                        duty_d[i] = '0;
                        dir_d[i]  = DIR_UP;
                    end
                    MODE_FIXED: begin
                        duty_d[i] = clamp_duty(shadow_q[i]);
                    end
                    default: begin
                        if (pend_q[i]) begin
                            duty_d[i] = clamp_duty(shadow_q[i]);
                            dir_d[i]  = DIR_UP;
                        end else if (step_q == SC_LAST) begin
                            if ((dir_q[i] == DIR_UP) || (mode_v[i] == MODE_RAMP)) begin
                                if (({1'b0, duty_q[i]} + STEP_X) >= PERIOD_X) begin
                                    duty_d[i] = PERIOD_C;
                                    dir_d[i]  = (mode_v[i] == MODE_RAMP) ? DIR_UP : DIR_DOWN;
                                end else begin
                                    duty_d[i] = duty_q[i] + STEP_C;
                                    dir_d[i]  = DIR_UP;
                                end
                            end else if ({1'b0, duty_q[i]} <= STEP_X) begin
                                duty_d[i] = '0;
                                dir_d[i]  = DIR_UP;
                            end else begin
                                duty_d[i] = duty_q[i] - STEP_C;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            step_q    <= '0;
            cyc_end_q <= 1'b0;
            duty_q    <= '0;
            shadow_q  <= '0;
            pend_q    <= '0;
            dout_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                dir_q[i] <= DIR_UP;
            end
        end else begin
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            cyc_end_q <= cyc_end_d;
            duty_q    <= duty_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            dout_q    <= dout_d;
            for (int i = 0; i < CHANNELS; i++) begin
                dir_q[i] <= dir_d[i];
            end
        end
    end

    assign pwm_if.dout      = dout_q;
    assign pwm_if.duty_out  = duty_q;
    assign pwm_if.cycle_end = cyc_end_q;

endmodule

// File: tb/tb_pwm_breathe_mc.sv
// Self-checking bench for pwm_breathe_mc: fixed-duty vector table plus breathe,
// ramp-hold, load-timing, async reset and enable-hold sequences.
module tb_pwm_breathe_mc;

    localparam int unsigned CH  = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned PER = 100;
    localparam int unsigned STP = 5;
    localparam int unsigned CPS = 1;

    logic clk;
    logic rst_n;

    pwm_breathe_mc_if #(.CHANNELS(CH), .CNT_W(W)) bus ();

    pwm_breathe_mc #(
        .CHANNELS    (CH),
        .CNT_W       (W),
        .PERIOD      (PER),
        .STEP        (STP),
        .CYC_PER_STEP(CPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_if(bus)
    );

    typedef struct {
        string       nm;
        int unsigned val;
    } exp_t;

    typedef struct {
        int unsigned din;
        int unsigned exp_duty;
        int unsigned exp_high;
    } vec_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int unsigned v);
        exp_t e;
        e.nm  = nm;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty actual=%0d", act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s actual=%0d required=%0d", e.nm, act, e.val);
            end
        end
    endtask

    function automatic logic [W-1:0] duty_of(input int ch);
        return bus.duty_out[W*ch +: W];
    endfunction

    task automatic set_mode(input int ch, input logic [1:0] m);
        bus.mode[2*ch +: 2] = m;
    endtask

    task automatic do_load(input int ch, input logic [W-1:0] v);
        bus.duty_in[W*ch +: W] = v;
        bus.load[ch] = 1'b1;
        tick();
        bus.load[ch] = 1'b0;
    endtask

    // Returns in the first cycle after a boundary edge (counter back at 0).
    task automatic wait_boundary();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 250 && !seen; n++) begin
            if (bus.cycle_end === 1'b1) seen = 1'b1;
            tick();
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL boundary_timeout actual=no_cycle_end required=cycle_end_within_250");
        end
    endtask

    // Observes one full period of dout[ch]; optionally pulses load[0] after sample load_at.
    task automatic measure(input int ch, input int load_at, input logic [W-1:0] lv,
                           output int highs, output int prefix, output int ces);
        bit low_seen;
        low_seen = 1'b0;
        highs    = 0;
        prefix   = 0;
        ces      = 0;
        for (int j = 0; j < int'(PER); j++) begin
            tick();
            if (bus.dout[ch] === 1'b1) begin
                highs++;
                if (!low_seen) prefix++;
            end else begin
                low_seen = 1'b1;
            end
            if (bus.cycle_end === 1'b1) ces++;
            if (j == load_at) begin
                bus.duty_in[W-1:0] = lv;
                bus.load[0] = 1'b1;
            end else begin
                bus.load[0] = 1'b0;
            end
        end
    endtask

    initial begin
        vec_t        vecs [6];
        int          hi, pf, ce, n;
        int unsigned t, e;

        vecs[0] = '{30, 30, 30};
        vecs[1] = '{0, 0, 0};
        vecs[2] = '{200, 100, 100};
        vecs[3] = '{100, 100, 100};
        vecs[4] = '{1, 1, 1};
        vecs[5] = '{99, 99, 99};

        rst_n       = 1'b0;
        bus.enable  = 1'b0;
        bus.mode    = '0;
        bus.duty_in = '0;
        bus.load    = '0;
        repeat (3) tick();

        expect_val("reset_dout", 0);       check(32'(bus.dout));
        expect_val("reset_duty_out", 0);   check(32'(bus.duty_out));
        expect_val("reset_cycle_end", 0);  check(32'(bus.cycle_end));

        rst_n      = 1'b1;
        bus.enable = 1'b1;

        // Fixed-duty table on channel 0
        for (int v = 0; v < 6; v++) begin
            set_mode(0, 2'b01);
            expect_val($sformatf("fixed%0d_duty_out", vecs[v].din), vecs[v].exp_duty);
            expect_val($sformatf("fixed%0d_high_clks", vecs[v].din), vecs[v].exp_high);
            expect_val($sformatf("fixed%0d_leading_high", vecs[v].din), vecs[v].exp_high);
            expect_val($sformatf("fixed%0d_cycle_end_count", vecs[v].din), 1);
            do_load(0, W'(vecs[v].din));
            wait_boundary();
            check(32'(duty_of(0)));
            measure(0, -1, '0, hi, pf, ce);
            check(32'(hi));
            check(32'(pf));
            check(32'(ce));
        end

        // Breathing triangle on channel 1 from 0
        set_mode(0, 2'b00);
        set_mode(1, 2'b10);
        for (int k = 1; k <= 42; k++) begin
            t = int'(k) % 40;
            e = (t <= 20) ? STP * t : STP * (40 - t);
            expect_val($sformatf("breathe_step%0d", k), e);
        end
        for (int k = 1; k <= 42; k++) begin
            wait_boundary();
            check(32'(duty_of(1)));
        end
        expect_val("off_ch0_duty", 0);
        check(32'(duty_of(0)));

        // Ramp-and-hold on channel 2
        set_mode(1, 2'b00);
        set_mode(2, 2'b11);
        for (int k = 1; k <= 25; k++) begin
            e = (STP * k > PER) ? PER : STP * k;
            expect_val($sformatf("ramp_step%0d", k), e);
        end
        for (int k = 1; k <= 25; k++) begin
            wait_boundary();
            check(32'(duty_of(2)));
        end
        expect_val("ramp_hold_high_clks", PER);
        measure(2, -1, '0, hi, pf, ce);
        check(32'(hi));
        expect_val("ramp_hold_duty", PER);
        check(32'(duty_of(2)));

        // Load timing on channel 0: mid-period and on the boundary edge
        set_mode(0, 2'b01);
        expect_val("midload_start_duty", 20);
        do_load(0, 8'd20);
        wait_boundary();
        check(32'(duty_of(0)));
        expect_val("midload_current_period_high", 20);
        measure(0, 9, 8'd50, hi, pf, ce);
        check(32'(hi));
        expect_val("midload_applied_duty", 50);
        check(32'(duty_of(0)));
        expect_val("midload_next_period_high", 50);
        measure(0, -1, '0, hi, pf, ce);
        check(32'(hi));
        expect_val("edgeload_same_period_high", 50);
        expect_val("edgeload_cycle_end_count", 1);
        measure(0, 98, 8'd70, hi, pf, ce);
        check(32'(hi));
        check(32'(ce));
        expect_val("edgeload_duty_after_edge", 50);
        check(32'(duty_of(0)));
        expect_val("edgeload_following_period_high", 50);
        measure(0, -1, '0, hi, pf, ce);
        check(32'(hi));
        expect_val("edgeload_duty_one_period_later", 70);
        check(32'(duty_of(0)));
        expect_val("edgeload_applied_period_high", 70);
        measure(0, -1, '0, hi, pf, ce);
        check(32'(hi));

        // Asynchronous reset mid-breath at cnt=57
        set_mode(1, 2'b10);
        wait_boundary();
        wait_boundary();
        repeat (57) tick();
        expect_val("pre_reset_dout", 32'h5);
        check(32'(bus.dout));
        expect_val("pre_reset_breathe_duty", 10);
        check(32'(duty_of(1)));
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_reset_dout", 0);       check(32'(bus.dout));
        expect_val("async_reset_duty_out", 0);   check(32'(bus.duty_out));
        expect_val("async_reset_cycle_end", 0);  check(32'(bus.cycle_end));
        repeat (2) tick();
        rst_n = 1'b1;
        expect_val("post_reset_duty_out", 0);
        check(32'(bus.duty_out));

        // Enable drop at cnt=57 for about 20 clocks
        do_load(0, 8'd80);
        wait_boundary();
        expect_val("enable_pre_duty_out", 32'h0005_0550);
        check(32'(bus.duty_out));
        repeat (57) tick();
        expect_val("enable_pre_dout", 32'h1);
        check(32'(bus.dout));
        bus.enable = 1'b0;
        n = 0;
        repeat (21) begin
            tick();
            if (bus.dout !== '0 || bus.cycle_end !== 1'b0) n++;
        end
        expect_val("disabled_active_cycles", 0);
        check(32'(n));
        expect_val("disabled_duty_hold", 32'h0005_0550);
        check(32'(bus.duty_out));
        bus.enable = 1'b1;
        n = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            n++;
            if (bus.cycle_end === 1'b1) break;
        end
        expect_val("resume_clks_to_cycle_end", 42);
        check(32'(n));

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_breathe_mc.md
Name: pwm_breathe_mc

Overview:
- Multi-channel PWM generator with one shared period counter and per-channel duty registers.
- Each channel runs in one of four modes: off, fixed duty, triangle breathing, or single ramp-and-hold.
- Duty changes take effect only at period boundaries, so outputs never glitch mid-period.
- Drives LED and motor-enable lines; configured by a simple register-strobe interface.

Parameters:
- CHANNELS, 4, number of independent PWM outputs (>=1).
- CNT_W, 8, width of the period counter and duty values.
- PERIOD, 100, PWM period in clk cycles (2..2^CNT_W-1).
- STEP, 5, duty increment/decrement per breathing step (>=1, <PERIOD).
- CYC_PER_STEP, 1, PWM periods between breathing steps (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global run; low freezes the counter and forces outputs low.
- mode  in  2*CHANNELS  per-channel mode, ch i at [2i+1:2i]: 00 off, 01 fixed, 10 breathe, 11 ramp-hold.
- duty_in  in  CNT_W*CHANNELS  per-channel duty value, ch i at [CNT_W*i +: CNT_W].
- load  in  CHANNELS  per-channel strobe: capture duty_in slice into the shadow register.
- dout  out  CHANNELS  registered PWM outputs.
- duty_out  out  CNT_W*CHANNELS  active (applied) duty per channel.
- cycle_end  out  1  one-clk pulse in the last cycle of each period.

Behaviour:
- Reset (asynchronous, reset=0):
  - cnt=0, step_cnt=0.
  - All active duty, shadow duty and dir (up) cleared.
  - dout=0, duty_out=0, cycle_end=0.
- Counter:
  - While enable=1, cnt counts 0..PERIOD-1 and wraps to 0.
  - cycle_end is registered and is 1 exactly in the clk cycle where cnt==PERIOD-1.
  - While enable=0: cnt, step_cnt and all duty/dir registers hold; dout=0; cycle_end=0. On re-enable, counting resumes from the held cnt.
- Output:
  - dout[i] is registered: dout[i] <= (enable && mode!=00 && cnt < duty[i]).
  - Latency is 1 clk from cnt to dout.
  - duty=0 gives constant low. duty>=PERIOD gives constant high.
  - High time is exactly duty clk cycles per period.
- Shadow load:
  - load[i]=1 captures the duty_in slice into shadow[i] on that edge.
  - Loads are accepted regardless of enable.
  - Multiple loads before a boundary: the last one wins.
- Boundary update, applied on the edge where cycle_end is asserted:
  - Off (00): duty[i] <= 0, dir <= up.
  - Fixed (01): duty[i] <= min(shadow[i], PERIOD).
  - Breathe (10), only when step_cnt==CYC_PER_STEP-1:
    - Up: if duty+STEP >= PERIOD then duty <= PERIOD and dir <= down; else duty <= duty+STEP.
    - Down: if duty <= STEP then duty <= 0 and dir <= up; else duty <= duty-STEP.
    - Arithmetic uses CNT_W+1 bits so there is no wrap.
  - Ramp-hold (11): same as breathe-up, but on reaching PERIOD the channel holds PERIOD; dir stays up.
- Mode-change and load coupling:
  - A load while in breathe or ramp-hold also sets duty[i] <= min(shadow, PERIOD) at the next boundary, instead of stepping, and sets dir <= up.
  - Switching mode from breathe to fixed takes effect at the next boundary.
- step_cnt:
  - Shared, counts boundaries 0..CYC_PER_STEP-1 and wraps.
  - With CYC_PER_STEP=1 every boundary is a step.
- Simultaneous events: a load on the boundary edge writes shadow. The update on that same edge uses the old shadow value.
- duty_out mirrors the active duty registers and changes only on boundary edges or reset.

Test Plan:
- Reset then enable=1, ch0 fixed, load duty 30, PERIOD=100 -> first period after the boundary: dout[0] high exactly 30 clks then low 70; cycle_end pulses every 100 clks.
- Fixed duty 0 and duty 200 (clamped) -> dout constant 0 and constant 1 respectively; duty_out reads 0 and 100.
- ch1 breathe, STEP=5, CYC_PER_STEP=1 from duty 0 -> duty_out sequence 5,10,...,100,95,...,0,5 per period; dir flips exactly at 100 and 0.
- ch2 ramp-hold from 0 -> reaches 100 after 20 periods, then stays 100; dout[2] constant high.
- Mid-period load of 50 in fixed mode at cnt=10 -> current period keeps the old duty; the next period has 50 high clks. Load on the cycle_end edge -> applied one period later.
- Assert reset low at cnt=57 mid-breath, and separately drop enable for 20 clks -> with reset low, all outputs are 0 immediately and async; after release, duty=0. With enable low, dout=0 and cnt holds 57; counting resumes at 57.
